// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port synchronous data memory between the pipeline MEM stage
// (CPU) and the sensor DMA port. The CPU wins in ARB. Once a DMA burst has
// started, the DMA keeps the memory (state BURST) until its last beat, until
// BURST_MAX beats have gone back to back, or until it drops its request. The
// pipeline is stalled while the CPU asks and is not granted.
//
// Handshake: a side is served in the cycle its grant is high. The memory
// command goes out in that same cycle. The DMA holds its payload stable while
// dma_req=1 and dma_gnt=0. Read data returns one cycle after the grant, flagged
// by cpu_rvalid / dma_rvalid. Writes never raise rvalid.
//
// Optional feature, macro ARB_STARVE_EN: a DMA that has waited STARVE_LIMIT
// cycles beats a CPU request in ARB. Without the macro, the CPU has strict
// priority in ARB.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   cpu_*             MEM-stage request, store payload, stall and load return
//   dma_*             DMA beat request and payload, beat accept, read return
//   mem_*             memory command (en/we/addr/wdata/funct3) and read data
//   dbg_state         current arbiter state (0 = ARB, 1 = BURST)
//   dbg_beat_cnt      beats granted so far in the current burst
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int BURST_MAX    = 8,
    parameter int STARVE_LIMIT = 16,
    localparam int BW          = $clog2(BURST_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [2:0]        cpu_funct3,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_last,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dbg_state,
    output logic [BW-1:0]     dbg_beat_cnt
);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t        state;
    logic [BW-1:0] beat_cnt;
    logic [BW-1:0] beat_next;
    logic          cpu_gnt;
    logic          starve_win;

`ifdef ARB_STARVE_EN
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    logic [WW-1:0] wait_cnt;

    // Saturates so a long-waiting DMA keeps its claim until it is served.
    assign starve_win = dma_req && (wait_cnt == WW'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (dma_gnt) begin
            wait_cnt <= '0;
        end else if (dma_req && (wait_cnt != WW'(STARVE_LIMIT))) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end
`else
    // The limit only matters when the starvation guard is built in.
    localparam int unused_starve_limit = STARVE_LIMIT;
    assign starve_win = 1'b0;
`endif

    // Grant selection. Reset forces both grants low so no memory command
    // leaks out while the block is held in reset.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (reset) begin
            if (state == ST_BURST) begin
                dma_gnt = dma_req;
            end else if (starve_win) begin
                dma_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else begin
                dma_gnt = dma_req;
            end
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_gnt;

    assign mem_en     = cpu_gnt | dma_gnt;
    assign mem_we     = dma_gnt ? dma_we    : (cpu_gnt & cpu_we);
    assign mem_addr   = dma_gnt ? dma_addr  : cpu_addr;
    assign mem_wdata  = dma_gnt ? dma_wdata : cpu_wdata;
    assign mem_funct3 = dma_gnt ? 3'b010    : cpu_funct3;

    // The memory has a single read port, so both sides see the same data bus.
    // Only the rvalid flags tell them apart.
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;

    assign beat_next    = beat_cnt + BW'(1);
    assign dbg_state    = state;
    assign dbg_beat_cnt = beat_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_ARB;
            beat_cnt   <= '0;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            dma_rvalid <= dma_gnt & ~dma_we;
            case (state)
                ST_ARB: begin
                    if (dma_gnt) begin
                        beat_cnt <= BW'(1);
                        // With BURST_MAX == 1 every beat is its own burst.
                        if (!dma_last && (BURST_MAX > 1)) begin
                            state <= ST_BURST;
                        end
                    end else begin
                        beat_cnt <= '0;
                    end
                end
                ST_BURST: begin
                    // Stay only while the DMA keeps streaming, has not flagged
                    // the last beat and has not used up its back-to-back quota.
                    if (dma_req && !dma_last && (beat_next != BW'(BURST_MAX))) begin
                        beat_cnt <= beat_next;
                    end else begin
                        state    <= ST_ARB;
                        beat_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_ARB;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter with default parameters (BURST_MAX=8,
// STARVE_LIMIT=16). It provides a small behavioural memory on the mem_* port.
// The bench runs directed table vectors for the burst and priority cases,
// hand-written sequences for loads, starvation and reset, and then a random
// phase checked against a rule-level reference model.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int BMAX = 8;
    localparam int SLIM = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [2:0]  cpu_funct3;
    logic        cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we, dma_last;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_funct3;
    logic        dbg_state;
    logic [3:0]  dbg_beat_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .BURST_MAX(BMAX), .STARVE_LIMIT(SLIM)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_last(dma_last),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state), .dbg_beat_cnt(dbg_beat_cnt)
    );

    // ---------------- clock / memory environment ----------------
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    logic [31:0] env_mem [256];
    bit          env_init_done = 1'b0;

    always @(posedge clk) begin
        if (!env_init_done) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
            env_init_done <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) env_mem[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= env_mem[mem_addr[9:2]];
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 32'h80; cpu_wdata = 0; cpu_funct3 = 3'b010;
        dma_req = 0; dma_we = 0; dma_addr = 32'h200; dma_wdata = 0; dma_last = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string name;
        logic  cpu_req, dma_req, dma_last;
        logic  e_cg, e_dg, e_stall, e_state;
        int    e_beat;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string n, logic c, logic d, logic l,
                                logic cg, logic dg, logic st, logic s, int b);
        vec_t v;
        v.name = n; v.cpu_req = c; v.dma_req = d; v.dma_last = l;
        v.e_cg = cg; v.e_dg = dg; v.e_stall = st; v.e_state = s; v.e_beat = b;
        vecs.push_back(v);
    endfunction

    // ---------------- reference model state ----------------
    bit          m_burst;
    int          m_beats;
    int          m_wait;
    logic [31:0] m_mem [256];
    bit          e_cpu_rv, e_dma_rv;
    logic [31:0] e_cpu_rd, e_dma_rd;
    bit          dma_pending;

    initial begin
        idle_inputs();
        reset = 1'b0;
        dma_req = 1; cpu_req = 1;    // requests must be ignored while in reset
        repeat (3) @(posedge clk);
        #1;
        check("rst dma_gnt", dma_gnt, 0);
        check("rst mem_en", mem_en, 0);
        check("rst state", dbg_state, 0);
        check("rst beat_cnt", dbg_beat_cnt, 0);
        check("rst cpu_rvalid", cpu_rvalid, 0);
        check("rst dma_rvalid", dma_rvalid, 0);
        idle_inputs();
        reset = 1'b1;
        next_cycle();

        // CPU load at 0x40: served at once, data one cycle later
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40; cpu_funct3 = 3'b100;
        #1;
        check("t1 cpu_stall", cpu_stall, 0);
        check("t1 mem_en", mem_en, 1);
        check("t1 mem_addr", mem_addr, 32'h40);
        check("t1 mem_we", mem_we, 0);
        check("t1 mem_funct3", mem_funct3, 3'b100);
        next_cycle();
        cpu_req = 0; cpu_funct3 = 3'b010;
        check("t1 cpu_rvalid", cpu_rvalid, 1);
        check("t1 cpu_rdata", cpu_rdata, init_word(16));
        check("t1 dma_rvalid", dma_rvalid, 0);
        next_cycle();
        check("t1 rvalid once", cpu_rvalid, 0);

        // name, cpu_req, dma_req, dma_last, cpu_gnt, dma_gnt, stall, state, beat
        add("t2b1",   0, 1, 0, 0, 1, 0, 0, 0);
        add("t2b2",   0, 1, 0, 0, 1, 0, 1, 1);
        add("t2b3",   0, 1, 0, 0, 1, 0, 1, 2);
        add("t2b4",   0, 1, 1, 0, 1, 0, 1, 3);
        add("t2idle", 0, 0, 0, 0, 0, 0, 0, 0);
        add("t3b1",   0, 1, 0, 0, 1, 0, 0, 0);
        add("t3b2",   1, 1, 0, 0, 1, 1, 1, 1);
        add("t3b3",   1, 1, 0, 0, 1, 1, 1, 2);
        add("t3b4",   1, 1, 1, 0, 1, 1, 1, 3);
        add("t3cpu",  1, 0, 0, 1, 0, 0, 0, 0);
        add("t3idle", 0, 0, 0, 0, 0, 0, 0, 0);
        add("t4b1",   0, 1, 0, 0, 1, 0, 0, 0);
        for (int k = 2; k <= BMAX; k++) add("t4bn", 1, 1, 0, 0, 1, 1, 1, k - 1);
        add("t4cpu",  1, 1, 0, 1, 0, 0, 0, 0);
        add("t4b9",   0, 1, 0, 0, 1, 0, 0, 0);
        add("t4b10",  0, 1, 0, 0, 1, 0, 1, 1);
        add("t4b11",  0, 1, 0, 0, 1, 0, 1, 2);
        add("t4b12",  0, 1, 1, 0, 1, 0, 1, 3);
        add("t4idle", 0, 0, 0, 0, 0, 0, 0, 0);
        add("drb1",   0, 1, 0, 0, 1, 0, 0, 0);
        add("drop",   1, 0, 0, 0, 0, 1, 1, 1);
        add("drcpu",  1, 0, 0, 1, 0, 0, 0, 0);
        add("dridle", 0, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            cpu_req  = vecs[k].cpu_req;
            dma_req  = vecs[k].dma_req;
            dma_last = vecs[k].dma_last;
            #1;
            check($sformatf("%s[%0d] state", vecs[k].name, k), dbg_state, vecs[k].e_state);
            check($sformatf("%s[%0d] beat_cnt", vecs[k].name, k), dbg_beat_cnt, 32'(vecs[k].e_beat));
            check($sformatf("%s[%0d] dma_gnt", vecs[k].name, k), dma_gnt, vecs[k].e_dg);
            check($sformatf("%s[%0d] cpu_gnt", vecs[k].name, k), mem_en & ~dma_gnt, vecs[k].e_cg);
            check($sformatf("%s[%0d] cpu_stall", vecs[k].name, k), cpu_stall, vecs[k].e_stall);
            next_cycle();
        end

        // Starvation: CPU requests every cycle while one DMA beat waits
        do_reset();
        cpu_req = 1; dma_req = 1; dma_last = 1;
`ifdef ARB_STARVE_EN
        for (int c = 1; c <= SLIM + 1; c++) begin
            #1;
            check($sformatf("t5 dma_gnt c%0d", c), dma_gnt, (c == SLIM + 1));
            check($sformatf("t5 cpu_stall c%0d", c), cpu_stall, (c == SLIM + 1));
            next_cycle();
        end
        dma_req = 0;
        #1;
        check("t5 cpu back", cpu_stall, 0);
`else
        for (int c = 1; c <= SLIM + 4; c++) begin
            #1;
            check($sformatf("t5 dma starve c%0d", c), dma_gnt, 0);
            check($sformatf("t5 cpu_stall c%0d", c), cpu_stall, 0);
            next_cycle();
        end
        cpu_req = 0;
        #1;
        check("t5 dma served", dma_gnt, 1);
`endif
        next_cycle();
        idle_inputs();
        next_cycle();

        // Reset on beat 3 of a DMA read burst
        dma_req = 1; dma_we = 0; dma_last = 0; dma_addr = 32'h300;
        #1;
        check("t6 b1 gnt", dma_gnt, 1);
        next_cycle();
        #1;
        check("t6 b2 gnt", dma_gnt, 1);
        check("t6 b1 rvalid", dma_rvalid, 1);
        check("t6 b1 rdata", dma_rdata, init_word(32'h300 >> 2));
        next_cycle();
        #1;
        check("t6 b3 gnt", dma_gnt, 1);
        check("t6 b2 rvalid", dma_rvalid, 1);
        reset = 1'b0;
        #1;
        check("t6 rst rvalid", dma_rvalid, 0);
        check("t6 rst dma_gnt", dma_gnt, 0);
        check("t6 rst mem_en", mem_en, 0);
        check("t6 rst state", dbg_state, 0);
        next_cycle();
        check("t6 held rvalid", dma_rvalid, 0);
        reset = 1'b1;
        dma_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80;
        #1;
        check("t6 post cpu_stall", cpu_stall, 0);
        check("t6 post mem_en", mem_en, 1);
        check("t6 post dma_rvalid", dma_rvalid, 0);
        next_cycle();
        cpu_req = 0;
        check("t6 post cpu_rvalid", cpu_rvalid, 1);
        check("t6 post cpu_rdata", cpu_rdata, init_word(32));
        check("t6 post dma_rvalid2", dma_rvalid, 0);

        // Random phase against the reference model
        do_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = init_word(i);
        m_burst = 0; m_beats = 0; m_wait = 0;
        e_cpu_rv = 0; e_dma_rv = 0; e_cpu_rd = 0; e_dma_rd = 0;
        dma_pending = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit mcg, mdg, starve;
            cpu_req    = ($urandom_range(0, 99) < 45);
            cpu_we     = $urandom_range(0, 1);
            cpu_addr   = 32'($urandom_range(0, 1023));
            cpu_wdata  = $urandom;
            cpu_funct3 = 3'($urandom_range(0, 7));
            if (!dma_pending && ($urandom_range(0, 99) < 55)) begin
                dma_pending = 1;
                dma_we      = $urandom_range(0, 1);
                dma_addr    = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                if ($urandom_range(0, 19) == 0) dma_addr[1:0] = 2'($urandom_range(1, 3));
                dma_wdata   = $urandom;
                dma_last    = ($urandom_range(0, 9) < 2);
            end
            dma_req = dma_pending;
            #1;

            mcg = 0; mdg = 0;
`ifdef ARB_STARVE_EN
            starve = dma_req && (m_wait >= SLIM);
`else
            starve = 0;
`endif
            if (m_burst)      mdg = dma_req;
            else if (starve)  mdg = 1;
            else if (cpu_req) mcg = 1;
            else              mdg = dma_req;

            check("rnd cpu_rvalid", cpu_rvalid, e_cpu_rv);
            check("rnd dma_rvalid", dma_rvalid, e_dma_rv);
            if (e_cpu_rv) check("rnd cpu_rdata", cpu_rdata, e_cpu_rd);
            if (e_dma_rv) check("rnd dma_rdata", dma_rdata, e_dma_rd);
            check("rnd dma_gnt", dma_gnt, mdg);
            check("rnd cpu_stall", cpu_stall, cpu_req && !mcg);
            check("rnd mem_en", mem_en, mcg || mdg);
            if (mcg) begin
                check("rnd cpu mem_addr", mem_addr, cpu_addr);
                check("rnd cpu mem_we", mem_we, cpu_we);
                check("rnd cpu mem_funct3", mem_funct3, cpu_funct3);
                if (cpu_we) check("rnd cpu mem_wdata", mem_wdata, cpu_wdata);
            end
            if (mdg) begin
                check("rnd dma mem_addr", mem_addr, dma_addr);
                check("rnd dma mem_we", mem_we, dma_we);
                check("rnd dma mem_funct3", mem_funct3, 3'b010);
                if (dma_we) check("rnd dma mem_wdata", mem_wdata, dma_wdata);
            end

            e_cpu_rv = mcg && !cpu_we;
            e_dma_rv = mdg && !dma_we;
            if (mcg) begin
                e_cpu_rd = m_mem[cpu_addr[9:2]];
                if (cpu_we) m_mem[cpu_addr[9:2]] = cpu_wdata;
            end
            if (mdg) begin
                e_dma_rd = m_mem[dma_addr[9:2]];
                if (dma_we) m_mem[dma_addr[9:2]] = dma_wdata;
                if (!m_burst) begin
                    m_beats = 1;
                    m_burst = !dma_last && (BMAX > 1);
                end else begin
                    m_beats++;
                    if (dma_last || m_beats == BMAX) begin
                        m_burst = 0;
                        m_beats = 0;
                    end
                end
                m_wait = 0;
                dma_pending = 0;
            end else begin
                if (m_burst) begin
                    m_burst = 0;
                    m_beats = 0;
                end
                if (dma_req && m_wait < SLIM) m_wait++;
            end
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
